regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file with an integrated scoreboard; successor to the 2R1W decode-stage register file.
- Adds configurable read and write port counts, deterministic multi-write priority, and per-register busy tracking for in-flight producers.
- Optional same-cycle write-to-read bypass.
- Sits in the decode stage. Issue logic allocates destinations; writeback ports retire them.

---
 rtl/regfile_mp_sb_pkg.sv | 14 +
 rtl/regfile_mp_sb_scoreboard.sv | 45 ++++
 rtl/regfile_mp_sb.sv | 91 +++++++++
 tb/tb_regfile_mp_sb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// rtl/regfile_mp_sb_pkg.sv - shared defaults, types and constants for the multi-port register file
package regfile_mp_sb_pkg;

    localparam int REG_COUNT  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // Index of the hardwired zero register
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// rtl/regfile_mp_sb_scoreboard.sv - per-register busy bits with set-over-clear priority and registered popcount
module rf_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int REG_N = REG_COUNT,
    parameter int CNT_W = $clog2(REG_N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_N-1:0] i_alloc_vec,
    input  logic [REG_N-1:0] i_clr_vec,
    output logic [REG_N-1:0] o_busy_vec,
    output logic [CNT_W-1:0] o_busy_cnt
);

    logic [REG_N-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [REG_N-1:0] w_next_busy;
    logic [CNT_W-1:0] w_next_cnt;

    // Next busy vector: a new allocation supersedes a retiring writeback; x0 never busy
    always_comb begin
        w_next_busy    = (r_busy & ~i_clr_vec) | i_alloc_vec;
        w_next_busy[0] = 1'b0;
        w_next_cnt     = '0;
        for (int i = 0; i < REG_N; i++) begin
            w_next_cnt = w_next_cnt + CNT_W'(w_next_busy[i]);
        end
    end

    // Busy vector and its popcount are registered together so they always agree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_next_busy;
            r_cnt  <= w_next_cnt;
        end
    end

    assign o_busy_vec = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with scoreboard; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int REG_N  = REG_COUNT,
    parameter int ADDR_W = $clog2(REG_N),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_i,
    input  logic                           alloc_i,
    input  logic [ADDR_W-1:0]              alloc_addr_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]              rd_busy_o,
    output logic [REG_N-1:0]               busy_vec_o,
    output logic [ADDR_W:0]                busy_cnt_o
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [REG_N];
    logic [REG_N-1:0]  w_alloc_vec;
    logic [REG_N-1:0]  w_clr_vec;
    logic [REG_N-1:0]  w_busy_vec;

    // Data array; ports are walked in ascending order so the highest port's write lands last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we_i[k] && (wr_addr_i[k] != ZERO_IDX)) begin
                    r_regs[wr_addr_i[k]] <= wr_data_i[k];
                end
            end
        end
    end

    // One-hot set/clear requests for the scoreboard; x0 is masked inside it
    always_comb begin
        w_alloc_vec = '0;
        w_clr_vec   = '0;
        if (alloc_i) begin
            w_alloc_vec[alloc_addr_i] = 1'b1;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k]) begin
                w_clr_vec[wr_addr_i[k]] = 1'b1;
            end
        end
    end

    rf_scoreboard #(
        .REG_N (REG_N),
        .CNT_W (ADDR_W + 1)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alloc_vec (w_alloc_vec),
        .i_clr_vec   (w_clr_vec),
        .o_busy_vec  (w_busy_vec),
        .o_busy_cnt  (busy_cnt_o)
    );

    assign busy_vec_o = w_busy_vec;

    // Read ports: array contents, optionally overridden by a same-cycle writeback
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            rd_data_o[j] = (rd_addr_i[j] == ZERO_IDX) ? '0 : r_regs[rd_addr_i[j]];
            rd_busy_o[j] = w_busy_vec[rd_addr_i[j]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (we_i[k] && (wr_addr_i[k] == rd_addr_i[j]) && (rd_addr_i[j] != ZERO_IDX)) begin
                    rd_data_o[j] = wr_data_i[k];
                    rd_busy_o[j] = alloc_i && (alloc_addr_i == rd_addr_i[j]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - self-checking bench: vector table, corner sequences, randomized model comparison
module tb_regfile_mp_sb;

    logic             clk;
    logic             rst_n;
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] wd;
    logic             al;
    logic [4:0]       aa;
    logic [1:0][4:0]  ra;
    logic [1:0][31:0] rd;
    logic [1:0]       rb;
    logic [31:0]      bv;
    logic [5:0]       bc;

    int checks = 0;
    int errors = 0;

    regfile_mp_sb #(
        .DATA_W (32),
        .REG_N  (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_i         (we),
        .wr_addr_i    (wa),
        .wr_data_i    (wd),
        .alloc_i      (al),
        .alloc_addr_i (aa),
        .rd_addr_i    (ra),
        .rd_data_o    (rd),
        .rd_busy_o    (rb),
        .busy_vec_o   (bv),
        .busy_cnt_o   (bc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; al = 1'b0; aa = '0;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [5:0]  ecnt;
        logic [1:0]  ebusy;
    } vec_t;

    vec_t tbl [11];

    // reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    initial begin
        tbl[0]  = '{2'b11, 5'd5, 32'hDEADBEEF, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 6'd0, 2'b00};
        tbl[1]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 6'd0, 2'b00};
        tbl[2]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 32'h0, 32'h22, 6'd1, 2'b01};
        tbl[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3, 32'h0, 32'h0, 6'd2, 2'b11};
        tbl[4]  = '{2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4, 32'h33, 32'h0, 6'd1, 2'b10};
        tbl[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd4, 32'h0, 32'h0, 6'd2, 2'b11};
        tbl[6]  = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd4, 32'h99, 32'h0, 6'd2, 2'b11};
        tbl[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h99, 6'd2, 2'b10};
        tbl[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3, 32'h0, 32'h33, 6'd2, 2'b01};
        tbl[9]  = '{2'b11, 5'd4, 32'h44, 5'd0, 32'hABCD, 1'b0, 5'd0, 5'd4, 5'd9, 32'h44, 32'h99, 6'd1, 2'b10};
        tbl[10] = '{2'b11, 5'd9, 32'hAA, 5'd9, 32'hBB, 1'b0, 5'd0, 5'd9, 5'd0, 32'hBB, 32'h0, 6'd0, 2'b00};

        idle();
        ra = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        ra[0] = 5'd1; ra[1] = 5'd31;
        #1;
        chk("reset_rd0", rd[0], 0);
        chk("reset_rd1", rd[1], 0);
        chk("reset_busyvec", bv, 0);
        chk("reset_cnt", bc, 0);
        chk("reset_rdbusy", rb, 0);

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we = tbl[i].we; wa[0] = tbl[i].wa0; wd[0] = tbl[i].wd0;
            wa[1] = tbl[i].wa1; wd[1] = tbl[i].wd1;
            al = tbl[i].al; aa = tbl[i].aa;
            @(posedge clk);
            #1;
            idle();
            ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
            #1;
            chk($sformatf("tbl%0d_rd0", i), rd[0], tbl[i].e0);
            chk($sformatf("tbl%0d_rd1", i), rd[1], tbl[i].e1);
            chk($sformatf("tbl%0d_cnt", i), bc, tbl[i].ecnt);
            chk($sformatf("tbl%0d_rdbusy", i), rb, tbl[i].ebusy);
        end

        // read-during-write on a busy register
        @(negedge clk);
        al = 1'b1; aa = 5'd6;
        @(negedge clk);
        idle();
        we[0] = 1'b1; wa[0] = 5'd6; wd[0] = 32'hA5A5; ra[0] = 5'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_data", rd[0], 32'hA5A5);
        chk("rdw_busy", rb[0], 1'b0);
`else
        chk("rdw_data", rd[0], 32'h0);
        chk("rdw_busy", rb[0], 1'b1);
`endif
        @(negedge clk);
        idle();
        #1;
        chk("rdw_after_data", rd[0], 32'hA5A5);
        chk("rdw_after_cnt", bc, 0);

        // write and allocate the same register while reading it
        @(negedge clk);
        we[0] = 1'b1; wa[0] = 5'd8; wd[0] = 32'h77; al = 1'b1; aa = 5'd8; ra[0] = 5'd8;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wra_data", rd[0], 32'h77);
        chk("wra_busy", rb[0], 1'b1);
`else
        chk("wra_data", rd[0], 32'h0);
        chk("wra_busy", rb[0], 1'b0);
`endif
        @(negedge clk);
        idle();
        #1;
        chk("wra_after_busy", rb[0], 1'b1);
        chk("wra_after_cnt", bc, 1);

        // asynchronous reset mid-cycle with live state; a write during reset must not land
        @(posedge clk);
        #3;
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hFFFF; ra[0] = 5'd5; ra[1] = 5'd8;
        rst_n = 1'b0;
        #1;
        chk("areset_rd0", rd[0], 0);
        chk("areset_rd1", rd[1], 0);
        chk("areset_busyvec", bv, 0);
        chk("areset_cnt", bc, 0);
        chk("areset_rdbusy", rb, 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk("areset_after_rd0", rd[0], 0);

        // randomized comparison against the reference model
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            logic [31:0] exp_d;
            bit          exp_b;
            logic [31:0] exp_v;
            @(negedge clk);
            exp_v = '0;
            for (int i = 0; i < 32; i++) exp_v[i] = m_busy[i];
            chk("rnd_busyvec", bv, exp_v);
            chk("rnd_cnt", bc, 6'(m_count()));
            for (int k = 0; k < 2; k++) begin
                we[k] = 1'($urandom_range(0, 1));
                wa[k] = 5'($urandom_range(0, 7));
                wd[k] = $urandom;
                ra[k] = 5'($urandom_range(0, 7));
            end
            al = 1'($urandom_range(0, 1));
            aa = 5'($urandom_range(0, 7));
            #1;
            for (int j = 0; j < 2; j++) begin
                exp_d = m_regs[ra[j]];
                exp_b = m_busy[ra[j]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < 2; k++) begin
                    if (we[k] && wa[k] == ra[j] && ra[j] != 0) begin
                        exp_d = wd[k];
                        exp_b = al && (aa == ra[j]);
                    end
                end
`endif
                chk($sformatf("rnd_rd%0d", j), rd[j], exp_d);
                chk($sformatf("rnd_rdbusy%0d", j), rb[j], exp_b);
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (we[k] && wa[k] != 0) m_regs[wa[k]] = wd[k];
                if (we[k]) m_busy[wa[k]] = 1'b0;
            end
            if (al && aa != 0) m_busy[aa] = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
